// File: rtl/qpsk_demod.sv
// QPSK receive slicer: hunts for a symbol-aligned sync byte, then descrambles
// the fixed-length payload with a 5-stage m-sequence and emits bytes.
module qpsk_demod #(
    parameter logic [4:0]  PN_SEED     = 5'b00001,
    parameter logic [7:0]  SYNC_WORD   = 8'hA5,
    parameter int unsigned FRAME_BYTES = 16
) (
    input  logic       CLK_50MHZ,
    input  logic       RESET,
    input  logic       in_valid,
    input  logic [7:0] dataI,
    input  logic [7:0] dataQ,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic       frame_done
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [7:0] win_q, win_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [1:0] sym_cnt_q, sym_cnt_d;
    logic [4:0] lfsr_q, lfsr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       frame_done_q, frame_done_d;

    logic       bit_i, bit_q, pn_i, pn_q, last_byte;
    logic [4:0] lfsr_mid;
    logic [7:0] win_next, shift_next;
    logic       sample_lsbs_unused;

    // Hard decision is the sign bit alone; magnitude carries no information here.
    assign bit_i = dataI[7];
    assign bit_q = dataQ[7];
    assign sample_lsbs_unused = ^{dataI[6:0], dataQ[6:0]};

    // The LFSR steps twice per symbol: I uses the current PN bit, Q the next one.
    assign lfsr_mid   = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    assign pn_i       = lfsr_q[4];
    assign pn_q       = lfsr_mid[4];
    assign win_next   = {win_q[5:0], bit_i, bit_q};
    assign shift_next = {shift_q[5:0], bit_i ^ pn_i, bit_q ^ pn_q};
    assign last_byte  = (byte_cnt_q == 8'(FRAME_BYTES - 1));

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        lfsr_d       = lfsr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (win_next == SYNC_WORD) begin
                        state_d    = LOCKED;
                        lfsr_d     = PN_SEED;
                        sym_cnt_d  = '0;
                        byte_cnt_d = '0;
                        shift_d    = '0;
                        win_d      = '0;
                    end else begin
                        win_d = win_next;
                    end
                end
                LOCKED: begin
                    lfsr_d    = {lfsr_mid[3:0], lfsr_mid[4] ^ lfsr_mid[2]};
                    shift_d   = shift_next;
                    sym_cnt_d = sym_cnt_q + 2'd1;
                    if (sym_cnt_q == 2'd3) begin
                        data_out_d   = shift_next;
                        data_valid_d = 1'b1;
                        byte_cnt_d   = byte_cnt_q + 8'd1;
                        if (last_byte) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                            win_d        = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge RESET) begin
        if (RESET) begin
            state_q      <= HUNT;
            win_q        <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            lfsr_q       <= PN_SEED;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            lfsr_q       <= lfsr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_qpsk_demod.sv
// Randomized bench for qpsk_demod: frames are built by a scrambling model and
// every emitted byte is matched against a queue of expected payload bytes.
module tb_qpsk_demod;

    localparam logic [4:0]  SEED = 5'b00001;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int unsigned FB   = 2;

    typedef logic [7:0] payload_t [FB];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] dataI, dataQ;
    logic [7:0] data_out;
    logic       data_valid, locked, frame_done;

    always #10 clk = ~clk;

    qpsk_demod #(
        .PN_SEED(SEED),
        .SYNC_WORD(SYNC),
        .FRAME_BYTES(FB)
    ) dut (
        .CLK_50MHZ(clk),
        .RESET(rst),
        .in_valid(in_valid),
        .dataI(dataI),
        .dataQ(dataQ),
        .data_out(data_out),
        .data_valid(data_valid),
        .locked(locked),
        .frame_done(frame_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One period of the x^5+x^3+1 sequence, as emitted from the top stage.
    bit pn_seq [31];

    function automatic logic [7:0] pn_byte(input int k);
        logic [7:0] r = '0;
        for (int b = 0; b < 8; b++) r = {r[6:0], pn_seq[(8 * k + b) % 31]};
        return r;
    endfunction

    logic [8:0]  exp_q [$];
    int unsigned n_valid = 0;
    bit          saw_lock = 0;
    logic        iv_edge = 1'b0;

    always @(posedge clk) iv_edge <= in_valid;

    always @(negedge clk) begin
        logic [8:0] e;
        if (locked) saw_lock = 1;
        if (data_valid) begin
            n_valid++;
            chk("valid_needs_sample", iv_edge, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", data_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", data_out, e[7:0]);
                chk("frame_done", frame_done, e[8]);
            end
        end else if (frame_done) begin
            chk("stray_frame_done", frame_done, 0);
        end
    end

    function automatic logic [7:0] smp(input bit b, input bit zero);
        if (b) return 8'h80 | 8'($urandom_range(0, 127));
        if (zero) return 8'h00;
        return 8'($urandom_range(0, 127));
    endfunction

    // Starts and ends one time unit after a rising edge.
    task automatic send_sym(input bit bi, input bit bq, input bit zero, input int unsigned gap);
        in_valid = 1'b1;
        dataI    = smp(bi, zero);
        dataQ    = smp(bq, zero);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dataI    = 8'($urandom);
        dataQ    = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit zero, input int unsigned gapmax);
        for (int s = 0; s < 4; s++)
            send_sym(v[7 - 2 * s], v[6 - 2 * s], zero, $urandom_range(0, gapmax));
    endtask

    task automatic send_frame(input payload_t pl, input int unsigned gapmax);
        for (int k = 0; k < FB; k++) exp_q.push_back({(k == FB - 1), pl[k]});
        send_byte(SYNC, 0, gapmax);
        chk("locked_after_sync", locked, 1);
        for (int k = 0; k < FB; k++) begin
            send_byte(pl[k] ^ pn_byte(k), 0, gapmax);
            if (k < FB - 1) chk("locked_mid_frame", locked, 1);
        end
        chk("locked_after_frame", locked, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        payload_t    pl;
        logic [7:0]  r;
        int unsigned nb;
        int          s;

        s = int'(SEED);
        for (int i = 0; i < 31; i++) begin
            pn_seq[i] = s[4];
            s = ((s << 1) & 31) | (((s >> 4) ^ (s >> 2)) & 1);
        end

        rst = 1'b1; in_valid = 1'b0; dataI = '0; dataQ = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Sync then raw 0x09, which the first PN byte cancels to zero.
        send_byte(SYNC, 0, 0);
        chk("A_locked", locked, 1);
        exp_q.push_back({1'b0, 8'h00});
        send_byte(8'h09, 0, 0);
        r = 8'($urandom);
        exp_q.push_back({1'b1, r});
        send_byte(r ^ pn_byte(1), 0, 0);
        chk("A_unlocked", locked, 0);

        // Raw zero samples decode to the first PN byte.
        send_byte(SYNC, 0, 0);
        exp_q.push_back({1'b0, 8'h09});
        send_byte(8'h00, 1, 0);
        r = 8'($urandom);
        exp_q.push_back({1'b1, r});
        send_byte(r ^ pn_byte(1), 0, 0);

        // Back-to-back frames, then the same payloads again with idle gaps.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < FB; k++) pl[k] = 8'($urandom);
            pl[0][0] = 1'b1;
            send_frame(pl, 0);
            send_frame(pl, 0);
            send_frame(pl, 5);
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("drained_1", exp_q.size(), 0);

        // Asynchronous reset in the middle of a payload byte.
        send_byte(SYNC, 0, 0);
        send_sym(1, 0, 0, 0);
        send_sym(0, 1, 0, 0);
        #5;
        rst = 1'b1;
        #1;
        chk("midrst_data_out", data_out, 0);
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nb = n_valid;
        saw_lock = 0;
        send_byte(8'h00, 0, 0);
        send_byte(8'hFF, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("postrst_no_valid", n_valid, nb);
        chk("postrst_no_lock", saw_lock, 0);

        // Sync pattern offset by one bit so it begins on a Q sample.
        for (int i = 0; i < 4; i++) send_sym(0, 0, 0, 0);
        nb = n_valid;
        saw_lock = 0;
        send_sym(0, 1, 0, 0);
        send_sym(0, 1, 0, 0);
        send_sym(0, 0, 0, 0);
        send_sym(1, 0, 0, 0);
        send_sym(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) send_sym(0, 0, 0, $urandom_range(0, 2));
        repeat (2) begin @(posedge clk); #1; end
        chk("misalign_no_lock", saw_lock, 0);
        chk("misalign_no_valid", n_valid, nb);

        // Still able to lock cleanly afterwards.
        for (int k = 0; k < FB; k++) pl[k] = 8'($urandom);
        send_frame(pl, 3);
        repeat (2) begin @(posedge clk); #1; end
        chk("drained_2", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
